// File: rtl/dmac_pkg.sv
// dmac_pkg: shared constants and types for the four-channel DMA controller.
//   VERSION    value returned at register offset 0x000
//   OFF_*      per-channel register offsets inside a channel page
//   CH_STRIDE  size of one channel page; channel n lives at (n+1)*CH_STRIDE
//   MAX_BEATS  longest burst and depth of the copy buffer (32-bit words)
package dmac_pkg;

  localparam logic [31:0] VERSION   = 32'h0001_2024;
  localparam logic [11:0] CH_STRIDE = 12'h100;
  localparam int          MAX_BEATS = 16;

  localparam logic [7:0] OFF_SRC  = 8'h00;
  localparam logic [7:0] OFF_DST  = 8'h04;
  localparam logic [7:0] OFF_LEN  = 8'h08;
  localparam logic [7:0] OFF_CMD  = 8'h0C;
  localparam logic [7:0] OFF_STAT = 8'h10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_RD,
    ST_AW,
    ST_WR,
    ST_B
  } dmac_state_t;

  function automatic logic [11:0] chan_base(input int ch);
    return 12'(CH_STRIDE * 12'(ch + 1));
  endfunction

endpackage

// File: rtl/dmac_cfg.sv
// dmac_cfg: APB register file for the DMA controller.
//   APB slave (zero wait states) : psel_i, penable_i, pwrite_i, paddr_i, pwdata_i -> prdata_o
//   cmpl_i                       : per-channel completion from the engine, sets STAT
//   start_o                      : per-channel start pulse, valid in the cycle of the CMD write
//   busy_o                       : per-channel busy (inverse of STAT.done)
//   src_o / dst_o / len_o        : programmed SRC/DST/LEN registers
module dmac_cfg
  import dmac_pkg::*;
#(
  parameter int          N_CH       = 4,
  parameter logic [31:0] IP_VERSION = VERSION
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     psel_i,
  input  logic                     penable_i,
  input  logic                     pwrite_i,
  input  logic [11:0]              paddr_i,
  input  logic [31:0]              pwdata_i,
  output logic [31:0]              prdata_o,
  input  logic [N_CH-1:0]          cmpl_i,
  output logic [N_CH-1:0]          start_o,
  output logic [N_CH-1:0]          busy_o,
  output logic [N_CH-1:0][31:0]    src_o,
  output logic [N_CH-1:0][31:0]    dst_o,
  output logic [N_CH-1:0][31:0]    len_o
);

  logic [N_CH-1:0] done_q;
  logic [N_CH-1:0] hit;
  logic [7:0]      off;
  logic            wr_en;
  logic            rd_en;

  assign off    = paddr_i[7:0];
  assign wr_en  = psel_i & penable_i & pwrite_i;
  assign rd_en  = psel_i & ~pwrite_i;
  assign busy_o = ~done_q;

  always_comb begin
    hit     = '0;
    start_o = '0;
    for (int c = 0; c < N_CH; c++) begin
      hit[c]     = ({paddr_i[11:8], 8'h00} == chan_base(c));
      // done_q doubles as the idle flag, so a CMD landing on a busy channel,
      // or on the cycle the engine finishes it, does nothing.
      start_o[c] = wr_en & hit[c] & (off == OFF_CMD) & pwdata_i[0] & done_q[c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_o  <= '0;
      dst_o  <= '0;
      len_o  <= '0;
      done_q <= '1;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (wr_en && hit[c] && off == OFF_SRC) src_o[c] <= pwdata_i;
        if (wr_en && hit[c] && off == OFF_DST) dst_o[c] <= pwdata_i;
        if (wr_en && hit[c] && off == OFF_LEN) len_o[c] <= pwdata_i;
        if (start_o[c])     done_q[c] <= 1'b0;
        else if (cmpl_i[c]) done_q[c] <= 1'b1;
      end
    end
  end

  always_comb begin
    prdata_o = '0;
    if (rd_en) begin
      if (paddr_i == 12'h000) prdata_o = IP_VERSION;
      for (int c = 0; c < N_CH; c++) begin
        if (hit[c]) begin
          case (off)
            OFF_SRC:  prdata_o = src_o[c];
            OFF_DST:  prdata_o = dst_o[c];
            OFF_LEN:  prdata_o = len_o[c];
            OFF_STAT: prdata_o = {31'b0, done_q[c]};
            default:  prdata_o = '0;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/dmac_top.sv
// dmac_top: four-channel memory-to-memory DMA with one shared AXI3 engine.
//   APB slave   : psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pready_o, prdata_o, pslverr_o
//   AXI3 master : AR/R read a burst into the buffer, AW/W/B write it back out
//
//   state   | meaning
//   IDLE    | round-robin pick of a busy channel with bytes left
//   AR      | read address presented, waiting for arready
//   RD      | collecting read beats into the buffer until rlast
//   AW      | write address presented, waiting for awready
//   WR      | streaming the buffer, wlast on the final beat
//   B       | waiting for the write response, then advance counters
module dmac_top
  import dmac_pkg::*;
#(
  parameter int          N_CH       = 4,
  parameter int          MAX_BEATS  = dmac_pkg::MAX_BEATS,
  parameter logic [31:0] IP_VERSION = 32'h0001_2024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [11:0] paddr_i,
  input  logic [31:0] pwdata_i,
  output logic        pready_o,
  output logic [31:0] prdata_o,
  output logic        pslverr_o,
  output logic [3:0]  awid_o,
  output logic [31:0] awaddr_o,
  output logic [3:0]  awlen_o,
  output logic [2:0]  awsize_o,
  output logic [1:0]  awburst_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [3:0]  wid_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wlast_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  input  logic [3:0]  bid_i,
  input  logic [1:0]  bresp_i,
  input  logic        bvalid_i,
  output logic        bready_o,
  output logic [3:0]  arid_o,
  output logic [31:0] araddr_o,
  output logic [3:0]  arlen_o,
  output logic [2:0]  arsize_o,
  output logic [1:0]  arburst_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  input  logic [3:0]  rid_i,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rlast_i,
  input  logic        rvalid_i,
  output logic        rready_o
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam int PW = $clog2(MAX_BEATS);

  logic [N_CH-1:0]       start, busy, cmpl, elig;
  logic [N_CH-1:0][31:0] src_cfg, dst_cfg, len_cfg;
  logic [N_CH-1:0][31:0] src_q, dst_q, len_q;

  dmac_state_t   state_q;
  logic [CW-1:0] ch_q, last_q, gnt_idx;
  logic          gnt_vld;
  logic [29:0]   gnt_words;
  logic [BW-1:0] gnt_beats, beats_q, cnt_q;
  logic [PW-1:0] ptr_q;
  logic [31:0]   burst_bytes;
  logic          b_hs;
  int            c_idx;
  logic [31:0]   buf_q [MAX_BEATS];

  logic unused_axi;
  assign unused_axi = ^{rid_i, rresp_i, bid_i, bresp_i};

  assign pready_o  = 1'b1;
  assign pslverr_o = 1'b0;
  assign arsize_o  = 3'd2;
  assign awsize_o  = 3'd2;
  assign arburst_o = 2'd1;
  assign awburst_o = 2'd1;
  assign wstrb_o   = 4'hF;

  dmac_cfg #(.N_CH(N_CH), .IP_VERSION(IP_VERSION)) u_cfg (
    .clk       (clk),
    .rst_n     (rst_n),
    .psel_i    (psel_i),
    .penable_i (penable_i),
    .pwrite_i  (pwrite_i),
    .paddr_i   (paddr_i),
    .pwdata_i  (pwdata_i),
    .prdata_o  (prdata_o),
    .cmpl_i    (cmpl),
    .start_o   (start),
    .busy_o    (busy),
    .src_o     (src_cfg),
    .dst_o     (dst_cfg),
    .len_o     (len_cfg)
  );

  assign b_hs        = bready_o & bvalid_i;
  assign burst_bytes = 32'(beats_q) << 2;

  // Zero-length channels are never granted; they complete straight from busy.
  always_comb begin
    elig = '0;
    cmpl = '0;
    for (int c = 0; c < N_CH; c++) begin
      elig[c] = busy[c] & (len_q[c][31:2] != '0);
      cmpl[c] = busy[c] & ((len_q[c][31:2] == '0) |
                           (b_hs & (ch_q == CW'(c)) & (len_q[c] == burst_bytes)));
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    c_idx   = 0;
    for (int i = 1; i <= N_CH; i++) begin
      c_idx = (int'(last_q) + i) % N_CH;
      if (!gnt_vld && elig[c_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = CW'(c_idx);
      end
    end
    gnt_words = len_q[gnt_idx][31:2];
    gnt_beats = (gnt_words > 30'(MAX_BEATS)) ? BW'(MAX_BEATS) : gnt_words[BW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (start[c]) begin
          src_q[c] <= src_cfg[c];
          dst_q[c] <= dst_cfg[c];
          len_q[c] <= len_cfg[c] & ~32'h3;
        end else if (b_hs && ch_q == CW'(c)) begin
          src_q[c] <= src_q[c] + burst_bytes;
          dst_q[c] <= dst_q[c] + burst_bytes;
          len_q[c] <= len_q[c] - burst_bytes;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_RD && rvalid_i) buf_q[ptr_q] <= rdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      last_q    <= '0;
      beats_q   <= '0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      arid_o    <= '0;
      araddr_o  <= '0;
      arlen_o   <= '0;
      arvalid_o <= 1'b0;
      rready_o  <= 1'b0;
      awid_o    <= '0;
      awaddr_o  <= '0;
      awlen_o   <= '0;
      awvalid_o <= 1'b0;
      wid_o     <= '0;
      wdata_o   <= '0;
      wlast_o   <= 1'b0;
      wvalid_o  <= 1'b0;
      bready_o  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (gnt_vld) begin
          ch_q      <= gnt_idx;
          last_q    <= gnt_idx;
          beats_q   <= gnt_beats;
          arid_o    <= 4'(gnt_idx);
          araddr_o  <= src_q[gnt_idx];
          arlen_o   <= 4'(gnt_beats - BW'(1));
          arvalid_o <= 1'b1;
          state_q   <= ST_AR;
        end
        ST_AR: if (arready_i) begin
          arvalid_o <= 1'b0;
          rready_o  <= 1'b1;
          ptr_q     <= '0;
          state_q   <= ST_RD;
        end
        ST_RD: if (rvalid_i) begin
          ptr_q <= ptr_q + PW'(1);
          if (rlast_i) begin
            rready_o  <= 1'b0;
            awid_o    <= 4'(ch_q);
            awaddr_o  <= dst_q[ch_q];
            awlen_o   <= arlen_o;
            awvalid_o <= 1'b1;
            state_q   <= ST_AW;
          end
        end
        ST_AW: if (awready_i) begin
          awvalid_o <= 1'b0;
          wvalid_o  <= 1'b1;
          wid_o     <= awid_o;
          wdata_o   <= buf_q[0];
          wlast_o   <= (beats_q == BW'(1));
          ptr_q     <= PW'(1);
          cnt_q     <= beats_q - BW'(1);
          state_q   <= ST_WR;
        end
        // cnt_q counts beats still to send after the one on the bus.
        ST_WR: if (wready_i) begin
          if (wlast_o) begin
            wvalid_o <= 1'b0;
            wlast_o  <= 1'b0;
            bready_o <= 1'b1;
            state_q  <= ST_B;
          end else begin
            wdata_o <= buf_q[ptr_q];
            ptr_q   <= ptr_q + PW'(1);
            cnt_q   <= cnt_q - BW'(1);
            wlast_o <= (cnt_q == BW'(1));
          end
        end
        ST_B: if (bvalid_i) begin
          bready_o <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmac_top.sv
module tb_dmac_top;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel_i, penable_i, pwrite_i;
  logic [11:0] paddr_i;
  logic [31:0] pwdata_i;
  logic        pready_o, pslverr_o;
  logic [31:0] prdata_o;
  logic [3:0]  awid_o, awlen_o, wid_o, wstrb_o, bid_i, arid_o, arlen_o, rid_i;
  logic [31:0] awaddr_o, wdata_o, araddr_o, rdata_i;
  logic [2:0]  awsize_o, arsize_o;
  logic [1:0]  awburst_o, arburst_o, bresp_i, rresp_i;
  logic        awvalid_o, awready_i, wlast_o, wvalid_o, wready_i, bvalid_i, bready_o;
  logic        arvalid_o, arready_i, rlast_i, rvalid_i, rready_o;

  always #5 clk = ~clk;

  dmac_top dut (
    .clk(clk), .rst_n(rst_n),
    .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
    .paddr_i(paddr_i), .pwdata_i(pwdata_i),
    .pready_o(pready_o), .prdata_o(prdata_o), .pslverr_o(pslverr_o),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
    .awburst_o(awburst_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
    .arburst_o(arburst_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
    .rvalid_i(rvalid_i), .rready_o(rready_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // 64 KB word-addressed memory behind the AXI slave.
  logic [31:0] mem [16384];

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'h5A5A_0000;
  endfunction

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
  } burst_t;

  burst_t ar_log[$];
  burst_t aw_log[$];
  int     proto_bad = 0;
  int     wlast_pos = 0;
  int     w_beat    = 0;
  logic   stall_en  = 1'b0;

  function automatic logic go();
    return stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
  endfunction

  // AXI slave: at each negedge it drives inputs and predicts the handshakes
  // of the next posedge (DUT outputs are registered, so stable until then).
  logic        rd_act, wr_act, b_pend, r_hs, b_hs;
  logic [31:0] rd_addr, wr_addr;
  logic [3:0]  rd_id, wr_id;
  int          rd_left, wr_left;

  initial begin
    arready_i = 0; rvalid_i = 0; rlast_i = 0; rdata_i = 0; rid_i = 0; rresp_i = 0;
    awready_i = 0; wready_i = 0; bvalid_i = 0; bid_i = 0; bresp_i = 0;
    rd_act = 0; wr_act = 0; b_pend = 0; r_hs = 0; b_hs = 0;
    rd_addr = 0; wr_addr = 0; rd_id = 0; wr_id = 0; rd_left = 0; wr_left = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        arready_i = 0; rvalid_i = 0; rlast_i = 0; awready_i = 0; wready_i = 0; bvalid_i = 0;
        rd_act = 0; wr_act = 0; b_pend = 0; r_hs = 0; b_hs = 0;
        continue;
      end
      if (rd_act) begin
        if (!rvalid_i || r_hs) rvalid_i = go();
        rid_i   = rd_id;
        rdata_i = mem[rd_addr[15:2]];
        rlast_i = (rd_left == 1);
        r_hs    = rvalid_i & rready_o;
        if (r_hs) begin
          rd_addr = rd_addr + 4;
          rd_left--;
          if (rd_left == 0) rd_act = 0;
        end
      end else begin
        rvalid_i = 0; rlast_i = 0; r_hs = 0;
      end
      if (!rd_act && arvalid_o) begin
        arready_i = go();
        if (arready_i) begin
          rd_act = 1; rd_addr = araddr_o; rd_left = int'(arlen_o) + 1; rd_id = arid_o;
          ar_log.push_back('{arid_o, araddr_o, arlen_o});
          if (arsize_o !== 3'd2 || arburst_o !== 2'd1) proto_bad++;
        end
      end else arready_i = 0;
      if (b_pend) begin
        if (!bvalid_i || b_hs) bvalid_i = go();
        bid_i = wr_id;
        b_hs  = bvalid_i & bready_o;
        if (b_hs) b_pend = 0;
      end else begin
        bvalid_i = 0; b_hs = 0;
      end
      if (wr_act) begin
        wready_i = go();
        if (wready_i && wvalid_o) begin
          mem[wr_addr[15:2]] = wdata_o;
          w_beat++;
          if (wlast_o !== (wr_left == 1)) proto_bad++;
          if (wlast_o) wlast_pos = w_beat;
          if (wid_o !== wr_id || wstrb_o !== 4'hF) proto_bad++;
          wr_addr = wr_addr + 4;
          wr_left--;
          if (wr_left == 0) begin wr_act = 0; b_pend = 1; end
        end
      end else wready_i = 0;
      if (!wr_act && !b_pend && awvalid_o) begin
        awready_i = go();
        if (awready_i) begin
          wr_act = 1; wr_addr = awaddr_o; wr_left = int'(awlen_o) + 1; wr_id = awid_o; w_beat = 0;
          aw_log.push_back('{awid_o, awaddr_o, awlen_o});
          if (awsize_o !== 3'd2 || awburst_o !== 2'd1) proto_bad++;
        end
      end else awready_i = 0;
    end
  end

  task automatic apb_wr(input logic [11:0] a, input logic [31:0] d);
    psel_i = 1; penable_i = 0; pwrite_i = 1; paddr_i = a; pwdata_i = d;
    @(negedge clk); penable_i = 1;
    @(negedge clk); psel_i = 0; penable_i = 0; pwrite_i = 0;
  endtask

  // prdata is combinational, so it is sampled in the setup cycle.
  task automatic apb_rd(input logic [11:0] a, output logic [31:0] d);
    psel_i = 1; penable_i = 0; pwrite_i = 0; paddr_i = a;
    #1 d = prdata_o;
    @(negedge clk); penable_i = 1;
    @(negedge clk); psel_i = 0; penable_i = 0;
  endtask

  function automatic logic [11:0] cb(input int ch);
    return 12'((ch + 1) * 256);
  endfunction

  task automatic prog(input int ch, input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
    apb_wr(cb(ch) + 12'h0, s);
    apb_wr(cb(ch) + 12'h4, d);
    apb_wr(cb(ch) + 12'h8, l);
  endtask

  task automatic wait_done(input int ch, input string tag);
    logic [31:0] s;
    int n = 0;
    do begin
      apb_rd(cb(ch) + 12'h10, s);
      n++;
    end while (s[0] !== 1'b1 && n < 3000);
    chk(tag, s, 32'h1);
  endtask

  task automatic check_copy(input string tag, input logic [31:0] s, input logic [31:0] d, input int len);
    int bad = 0;
    for (int i = 0; i < len / 4; i++) begin
      logic [31:0] da;
      da = d + 32'(4 * i);
      if (mem[da[15:2]] !== pat(s + 32'(4 * i))) bad++;
    end
    chk(tag, 32'(bad), 32'h0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] srcs [4];
    logic [31:0] dsts [4];
    psel_i = 0; penable_i = 0; pwrite_i = 0; paddr_i = 0; pwdata_i = 0;
    for (int i = 0; i < 16384; i++) mem[i] = pat(32'(i * 4));
    repeat (3) @(negedge clk);
    chk("rst_valids", {27'b0, arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o}, 32'h0);
    rst_n = 1;
    @(negedge clk);
    chk("rst_araddr", araddr_o, 32'h0);
    chk("rst_lens", {24'b0, arlen_o, awlen_o}, 32'h0);
    chk("apb_resp", {30'b0, pready_o, pslverr_o}, 32'h2);

    apb_rd(12'h000, rd); chk("version", rd, 32'h0001_2024);
    for (int c = 0; c < 4; c++) begin
      apb_rd(cb(c) + 12'h10, rd); chk("stat_rst", rd, 32'h1);
    end
    apb_rd(12'h10C, rd); chk("cmd_rd0", rd, 32'h0);
    apb_wr(12'h114, 32'hFFFF_FFFF);
    apb_rd(12'h114, rd); chk("unmapped", rd, 32'h0);

    prog(0, 32'h0, 32'h2000, 32'h100);
    apb_rd(12'h100, rd); chk("rb_src", rd, 32'h0);
    apb_rd(12'h104, rd); chk("rb_dst", rd, 32'h2000);
    apb_rd(12'h108, rd); chk("rb_len", rd, 32'h100);

    // ch0 single-channel copy, four full bursts
    apb_wr(12'h10C, 32'h1);
    apb_rd(12'h110, rd); chk("stat_busy", rd, 32'h0);
    wait_done(0, "ch0_done");
    chk("ch0_nbursts", 32'(ar_log.size()), 32'd4);
    for (int k = 0; k < ar_log.size() && k < 4; k++) begin
      chk("ch0_arlen", 32'(ar_log[k].len), 32'd15);
      chk("ch0_arid", 32'(ar_log[k].id), 32'd0);
      chk("ch0_araddr", ar_log[k].addr, 32'(k * 64));
    end
    for (int k = 0; k < aw_log.size() && k < 4; k++) begin
      chk("ch0_awlen", 32'(aw_log[k].len), 32'd15);
      chk("ch0_awaddr", aw_log[k].addr, 32'h2000 + 32'(k * 64));
    end
    check_copy("ch0_data", 32'h0, 32'h2000, 256);

    // four channels, round-robin
    ar_log.delete(); aw_log.delete();
    for (int c = 0; c < 4; c++) begin
      srcs[c] = 32'(c * 32'h400);
      dsts[c] = 32'((c + 1) * 32'h2000);
      prog(c, srcs[c], dsts[c], 32'h100);
    end
    for (int c = 0; c < 4; c++) apb_wr(cb(c) + 12'hC, 32'h1);
    for (int c = 0; c < 4; c++) wait_done(c, "mc_done");
    chk("mc_nbursts", 32'(ar_log.size()), 32'd16);
    for (int k = 0; k < ar_log.size() && k < 16; k++) begin
      chk("mc_arid", 32'(ar_log[k].id), 32'(k % 4));
      chk("mc_araddr", ar_log[k].addr, srcs[k % 4] + 32'((k / 4) * 64));
    end
    for (int k = 0; k < aw_log.size() && k < 16; k++)
      chk("mc_awid", 32'(aw_log[k].id), 32'(k % 4));
    for (int c = 0; c < 4; c++) check_copy("mc_data", srcs[c], dsts[c], 256);

    // 9-beat burst
    ar_log.delete(); aw_log.delete();
    prog(1, 32'h1000, 32'hA000, 32'h24);
    apb_wr(cb(1) + 12'hC, 32'h1);
    wait_done(1, "b9_done");
    chk("b9_nbursts", 32'(ar_log.size()), 32'd1);
    if (ar_log.size() > 0) chk("b9_arlen", 32'(ar_log[0].len), 32'd8);
    if (aw_log.size() > 0) chk("b9_awlen", 32'(aw_log[0].len), 32'd8);
    chk("b9_wlast_pos", 32'(wlast_pos), 32'd9);
    check_copy("b9_data", 32'h1000, 32'hA000, 36);
    chk("b9_no_overrun", mem[16'hA024 >> 2], pat(32'hA024));

    // zero length
    prog(2, 32'h1100, 32'hB000, 32'h0);
    apb_wr(cb(2) + 12'hC, 32'h1);
    apb_rd(cb(2) + 12'h10, rd); chk("z_stat0", rd, 32'h0);
    apb_rd(cb(2) + 12'h10, rd); chk("z_stat1", rd, 32'h1);
    repeat (20) @(negedge clk);
    chk("z_no_axi", 32'(ar_log.size() + aw_log.size()), 32'd1 + 32'd1);

    // busy-channel CMD and register writes under random stalls
    ar_log.delete(); aw_log.delete();
    stall_en = 1'b1;
    prog(3, 32'h1400, 32'hC000, 32'h82);
    apb_wr(cb(3) + 12'hC, 32'h1);
    apb_wr(cb(3) + 12'h0, 32'h1800);
    apb_wr(cb(3) + 12'hC, 32'h1);
    wait_done(3, "st_done");
    repeat (40) @(negedge clk);
    chk("st_nbursts", 32'(ar_log.size()), 32'd2);
    if (aw_log.size() > 1) chk("st_awaddr1", aw_log[1].addr, 32'hC040);
    check_copy("st_data", 32'h1400, 32'hC000, 128);
    chk("st_no_overrun", mem[16'hC080 >> 2], pat(32'hC080));
    apb_rd(cb(3) + 12'h0, rd); chk("st_src_rb", rd, 32'h1800);
    apb_rd(cb(3) + 12'h8, rd); chk("st_len_rb", rd, 32'h82);
    stall_en = 1'b0;
    chk("axi_proto", 32'(proto_bad), 32'h0);

    // reset in the middle of a transfer
    prog(0, 32'h0, 32'hD000, 32'h100);
    apb_wr(cb(0) + 12'hC, 32'h1);
    repeat (10) @(negedge clk);
    rst_n = 0;
    #1 chk("mid_rst_valids", {27'b0, arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    apb_rd(cb(0) + 12'h10, rd); chk("mid_rst_stat", rd, 32'h1);
    apb_rd(cb(0) + 12'h4, rd); chk("mid_rst_dst", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
